// File: rtl/tick_scheduler.sv
// Run-controlled strobe generator: divides clk_in into fast and slow single-cycle
// clock-enable ticks, gated by an IDLE/RUN/PAUSE FSM with run-time divisor reload.
module tick_scheduler #(
    parameter int unsigned FAST_DIV = 1000,
    parameter int unsigned SLOW_DIV = 100000,
    parameter int unsigned CNT_W    = 17
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             cfg_valid,
    input  logic             cfg_sel,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             tick_fast,
    output logic             tick_slow,
    output logic             running
);

    localparam logic [CNT_W-1:0] FAST_INIT = CNT_W'(FAST_DIV);
    localparam logic [CNT_W-1:0] SLOW_INIT = CNT_W'(SLOW_DIV);
    localparam logic [CNT_W-1:0] DIV_MIN   = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] fast_cnt_q, fast_cnt_d;
    logic [CNT_W-1:0] slow_cnt_q, slow_cnt_d;
    logic [CNT_W-1:0] fast_div_q, fast_div_d;
    logic [CNT_W-1:0] slow_div_q, slow_div_d;
    logic             tick_fast_q, tick_fast_d;
    logic             tick_slow_q, tick_slow_d;
    logic             running_q, running_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             count_en;
    logic [CNT_W-1:0] div_clamped;

    // Next-state, counting and reload logic
    always_comb begin
        state_d     = state_q;
        fast_cnt_d  = fast_cnt_q;
        slow_cnt_d  = slow_cnt_q;
        fast_div_d  = fast_div_q;
        slow_div_d  = slow_div_q;
        tick_fast_d = 1'b0;
        tick_slow_d = 1'b0;
        count_en    = (state_q == RUN) && !stop && !clear;
        div_clamped = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;

        if (clear) begin
            state_d = IDLE;
        end else if (stop) begin
            if (state_q == RUN) state_d = PAUSE;
        end else if (start) begin
            if (state_q == IDLE || state_q == PAUSE) state_d = RUN;
        end

        if (count_en) begin
            if (fast_cnt_q == fast_div_q - ONE) begin
                fast_cnt_d  = '0;
                tick_fast_d = 1'b1;
            end else begin
                fast_cnt_d = fast_cnt_q + ONE;
            end
            if (slow_cnt_q == slow_div_q - ONE) begin
                slow_cnt_d  = '0;
                tick_slow_d = 1'b1;
            end else begin
                slow_cnt_d = slow_cnt_q + ONE;
            end
        end

        // Ready is only ever high outside RUN, so a reload never races the counters
        if (cfg_valid && cfg_ready_q) begin
            if (cfg_sel) begin
                slow_div_d = div_clamped;
                slow_cnt_d = '0;
            end else begin
                fast_div_d = div_clamped;
                fast_cnt_d = '0;
            end
        end

        if (clear) begin
            fast_cnt_d = '0;
            slow_cnt_d = '0;
        end

        running_d   = (state_d == RUN);
        cfg_ready_d = (state_d != RUN);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q     <= IDLE;
            fast_cnt_q  <= '0;
            slow_cnt_q  <= '0;
            fast_div_q  <= FAST_INIT;
            slow_div_q  <= SLOW_INIT;
            tick_fast_q <= 1'b0;
            tick_slow_q <= 1'b0;
            running_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            fast_cnt_q  <= fast_cnt_d;
            slow_cnt_q  <= slow_cnt_d;
            fast_div_q  <= fast_div_d;
            slow_div_q  <= slow_div_d;
            tick_fast_q <= tick_fast_d;
            tick_slow_q <= tick_slow_d;
            running_q   <= running_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign tick_fast = tick_fast_q;
    assign tick_slow = tick_slow_q;
    assign running   = running_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: start latency, periods, reload handshake,
// pause/resume phase, control priorities and mid-run reset.
module tb_tick_scheduler;

    localparam int unsigned CNT_W = 17;

    logic             clk_in = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             clear = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_sel = 1'b0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             cfg_ready;
    logic             tick_fast;
    logic             tick_slow;
    logic             running;

    int checks = 0;
    int failures = 0;
    int slow_seen = 0;

    tick_scheduler #(.FAST_DIV(1000), .SLOW_DIV(100000), .CNT_W(CNT_W)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .cfg_valid(cfg_valid),
        .cfg_sel  (cfg_sel),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .tick_fast(tick_fast),
        .tick_slow(tick_slow),
        .running  (running)
    );

    always #1 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One active edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk_in);
        #0.5;
    endtask

    // Edges until tick_fast is observed high; -1 if the budget expires
    task automatic measure(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (tick_slow) slow_seen++;
            if (tick_fast) begin
                n = i;
                break;
            end
        end
    endtask

    // Bit i of each mask = tick value observed after the i-th edge
    task automatic record(input int nsteps, output logic [31:0] fm, output logic [31:0] sm);
        fm = '0;
        sm = '0;
        for (int i = 1; i <= nsteps; i++) begin
            step();
            fm[i] = tick_fast;
            sm[i] = tick_slow;
        end
    endtask

    task automatic reload(input logic sel, input logic [CNT_W-1:0] div);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_div   = div;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        logic [31:0] fm, sm;

        // Reset values
        step();
        step();
        chk("rst_tick_fast", 32'(tick_fast), 32'd0);
        chk("rst_tick_slow", 32'(tick_slow), 32'd0);
        chk("rst_running",   32'(running),   32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b1;
        step();

        // Default divisors: first fast tick 1000 edges after start, period 1000
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_running", 32'(running), 32'd1);
        chk("start_ready",   32'(cfg_ready), 32'd0);
        measure(1200, n);
        chk("default_first_fast", 32'(n), 32'd1000);
        step();
        chk("default_fast_width", 32'(tick_fast), 32'd0);
        measure(1200, n);
        chk("default_fast_period", 32'(n + 1), 32'd1000);
        chk("default_no_slow", 32'(slow_seen), 32'd0);

        // Reload in IDLE: fast=4, slow=10, then fast=1 clamps to 2
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_running", 32'(running), 32'd0);
        chk("clear_ready",   32'(cfg_ready), 32'd1);
        reload(1'b0, 17'd4);
        reload(1'b1, 17'd10);
        reload(1'b0, 17'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        record(12, fm, sm);
        chk("clamp_fast_mask", fm, 32'h0000_1554);
        chk("reload_slow_mask", sm, 32'h0000_0400);

        // cfg_valid held in RUN must not transfer
        cfg_valid = 1'b1;
        cfg_sel   = 1'b0;
        cfg_div   = 17'd7;
        record(6, fm, sm);
        chk("run_ready_low", 32'(cfg_ready), 32'd0);
        chk("run_no_transfer", fm, 32'h0000_0054);
        cfg_valid = 1'b0;

        // Pause/resume phase with fast=4
        clear = 1'b1;
        step();
        clear = 1'b0;
        reload(1'b0, 17'd4);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        stop = 1'b1;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (tick_fast || tick_slow || running || !cfg_ready) bad++;
        end
        stop = 1'b0;
        chk("pause_quiet", 32'(bad), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("resume_running", 32'(running), 32'd1);
        measure(10, n);
        chk("resume_phase", 32'(n), 32'd2);

        // start+stop in RUN and PAUSE -> PAUSE
        start = 1'b1;
        stop  = 1'b1;
        step();
        chk("startstop_run", 32'(running), 32'd0);
        chk("startstop_run_ready", 32'(cfg_ready), 32'd1);
        step();
        chk("startstop_pause", 32'(running), 32'd0);
        stop  = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_start", 32'(running), 32'd0);
        stop = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b0;
        chk("startstop_idle", 32'(running), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        measure(10, n);
        chk("clear_zeroed_fast", 32'(n), 32'd4);

        // PAUSE reload of slow zeroes slow only; fast keeps its held count
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        reload(1'b1, 17'd5);
        start = 1'b1;
        step();
        start = 1'b0;
        record(8, fm, sm);
        chk("pause_reload_fast", fm, 32'h0000_0088);
        chk("pause_reload_slow", sm, 32'h0000_0020);

        // Reset on a fast wrap edge: no tick, reset values, default divisors
        step();
        step();
        rst = 1'b0;
        step();
        chk("rstrun_tick_fast", 32'(tick_fast), 32'd0);
        chk("rstrun_tick_slow", 32'(tick_slow), 32'd0);
        chk("rstrun_running",   32'(running),   32'd0);
        chk("rstrun_ready",     32'(cfg_ready), 32'd1);
        rst = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        measure(1200, n);
        chk("rstrun_default_div", 32'(n), 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
